// File: rtl/inst_seq_ctrl_if.sv
// Handshake and control bundle between the sequencing FSM and its fetch,
// decode, execute, load/store and register-file neighbours.
interface inst_seq_ctrl_if;
  logic        ifu_req_valid;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic [31:0] inst_q;
  logic [6:0]  op;
  logic        ex_en;
  logic [63:0] pc_next;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic        lsu_resp_valid;
  logic        rf_wen;
  logic [63:0] pc;
  logic        halt;
  logic [1:0]  err;

  modport master (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_resp_valid, ifu_resp_inst,
    output inst_q,
    input  op,
    output ex_en,
    input  pc_next,
    output lsu_req_valid, lsu_req_wen,
    input  lsu_resp_valid,
    output rf_wen, pc, halt, err
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_resp_valid, ifu_resp_inst,
    input  inst_q,
    output op,
    input  ex_en,
    output pc_next,
    input  lsu_req_valid, lsu_req_wen,
    output lsu_resp_valid,
    input  rf_wen, pc, halt, err
  );
endinterface

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Owns the PC and halts on ebreak, illegal opcode or memory timeout.
module inst_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  inst_seq_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [63:0]      pc;

  function automatic logic is_legal(input logic [6:0] o);
    case (o)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011,
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0100011,
      7'b0110011, 7'b0011011, 7'b0111011, 7'b1110011: is_legal = 1'b1;
      default:                                        is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rf(input logic [6:0] o);
    writes_rf = !(o == OP_BRANCH || o == OP_STORE || o == OP_SYSTEM);
  endfunction

  assign bus.pc           = pc;
  assign bus.ifu_req_addr = pc;

  // Strobes are registered, so each is set on the edge entering its state.
  // The wait counter reaching WAIT_LAST means this is the TIMEOUT-th
  // unanswered cycle; a response in that same cycle still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      pc                <= RESET_PC;
      wait_cnt          <= '0;
      bus.inst_q        <= '0;
      bus.halt          <= 1'b0;
      bus.err           <= '0;
      bus.ifu_req_valid <= 1'b0;
      bus.ex_en         <= 1'b0;
      bus.lsu_req_valid <= 1'b0;
      bus.lsu_req_wen   <= 1'b0;
      bus.rf_wen        <= 1'b0;
    end else begin
      bus.ex_en  <= 1'b0;
      bus.rf_wen <= 1'b0;
      case (state)
        IDLE: begin
          state             <= FETCH;
          bus.ifu_req_valid <= 1'b1;
          wait_cnt          <= '0;
        end
        FETCH: begin
          if (bus.ifu_resp_valid) begin
            bus.inst_q        <= bus.ifu_resp_inst;
            bus.ifu_req_valid <= 1'b0;
            state             <= DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.ifu_req_valid <= 1'b0;
            bus.halt          <= 1'b1;
            bus.err           <= 2'd2;
            state             <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DECODE: begin
          if (!is_legal(bus.op)) begin
            bus.halt <= 1'b1;
            bus.err  <= 2'd1;
            state    <= HALT;
          end else if (bus.inst_q == EBREAK) begin
            bus.halt <= 1'b1;
            bus.err  <= 2'd0;
            state    <= HALT;
          end else begin
            bus.ex_en <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (bus.op == OP_LOAD || bus.op == OP_STORE) begin
            bus.lsu_req_valid <= 1'b1;
            bus.lsu_req_wen   <= (bus.op == OP_STORE);
            wait_cnt          <= '0;
            state             <= MEM;
          end else begin
            bus.rf_wen <= writes_rf(bus.op);
            state      <= WB;
          end
        end
        MEM: begin
          if (bus.lsu_resp_valid) begin
            bus.lsu_req_valid <= 1'b0;
            bus.lsu_req_wen   <= 1'b0;
            bus.rf_wen        <= writes_rf(bus.op);
            state             <= WB;
          end else if (wait_cnt == WAIT_LAST) begin
            bus.lsu_req_valid <= 1'b0;
            bus.lsu_req_wen   <= 1'b0;
            bus.halt          <= 1'b1;
            bus.err           <= 2'd2;
            state             <= HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WB: begin
          pc                <= bus.pc_next;
          bus.ifu_req_valid <= 1'b1;
          wait_cnt          <= '0;
          state             <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Directed bench for inst_seq_ctrl: ALU op, store/load, branch, late-response
// boundary, ebreak, illegal op, fetch timeout and mid-request reset.
module tb_inst_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        use_br = 1'b0;
  logic [63:0] br_target = '0;
  int          checks = 0;
  int          failures = 0;

  inst_seq_ctrl_if bus ();

  assign bus.op      = bus.inst_q[6:0];
  assign bus.pc_next = use_br ? br_target : bus.pc + 64'd4;

  inst_seq_ctrl #(.RESET_PC(64'h8000_0000), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch_resp(input logic [31:0] inst);
    bus.ifu_resp_valid = 1'b1;
    bus.ifu_resp_inst  = inst;
    tick();
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_inst  = '0;
  endtask

  initial begin
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_inst  = '0;
    bus.lsu_resp_valid = 1'b0;

    tick();
    tick();
    check("rst_pc", bus.pc, 64'h8000_0000);
    check("rst_inst_q", bus.inst_q, '0);
    check("rst_halt", bus.halt, 1'b0);
    check("rst_err", bus.err, 2'd0);
    check("rst_ifu_req", bus.ifu_req_valid, 1'b0);
    check("rst_lsu_req", bus.lsu_req_valid, 1'b0);
    check("rst_rf_wen", bus.rf_wen, 1'b0);
    check("rst_ex_en", bus.ex_en, 1'b0);
    rst = 1'b0;
    tick();
    check("t1_ifu_req", bus.ifu_req_valid, 1'b1);
    check("t1_addr", bus.ifu_req_addr, 64'h8000_0000);

    // addi x1,x0,1
    fetch_resp(32'h0010_0093);
    check("t1_inst_q", bus.inst_q, 32'h0010_0093);
    check("t1_req_drop", bus.ifu_req_valid, 1'b0);
    tick();
    check("t1_ex_en", bus.ex_en, 1'b1);
    check("t1_rf_wen_exec", bus.rf_wen, 1'b0);
    tick();
    check("t1_rf_wen_wb", bus.rf_wen, 1'b1);
    check("t1_ex_en_once", bus.ex_en, 1'b0);
    check("t1_pc_in_wb", bus.pc, 64'h8000_0000);
    tick();
    check("t1_rf_wen_off", bus.rf_wen, 1'b0);
    check("t1_pc_next", bus.pc, 64'h8000_0004);
    check("t1_refetch", bus.ifu_req_valid, 1'b1);

    // sw, data response three cycles late; a stray fetch response must be ignored
    fetch_resp(32'h0011_2023);
    tick();
    tick();
    check("t2_lsu_req_c1", bus.lsu_req_valid, 1'b1);
    check("t2_wen_c1", bus.lsu_req_wen, 1'b1);
    bus.ifu_resp_valid = 1'b1;
    bus.ifu_resp_inst  = 32'hDEAD_BEEF;
    tick();
    bus.ifu_resp_valid = 1'b0;
    check("t2_wen_c2", bus.lsu_req_wen, 1'b1);
    check("t2_stray_ifu", bus.inst_q, 32'h0011_2023);
    tick();
    check("t2_wen_c3", bus.lsu_req_wen, 1'b1);
    tick();
    check("t2_wen_c4", bus.lsu_req_wen, 1'b1);
    check("t2_lsu_req_c4", bus.lsu_req_valid, 1'b1);
    bus.lsu_resp_valid = 1'b1;
    tick();
    bus.lsu_resp_valid = 1'b0;
    check("t2_lsu_drop", bus.lsu_req_valid, 1'b0);
    check("t2_store_no_wb", bus.rf_wen, 1'b0);
    tick();
    check("t2_pc", bus.pc, 64'h8000_0008);

    // lw, zero-wait data response
    fetch_resp(32'h0001_2083);
    tick();
    tick();
    check("ld_wen", bus.lsu_req_wen, 1'b0);
    check("ld_lsu_req", bus.lsu_req_valid, 1'b1);
    bus.lsu_resp_valid = 1'b1;
    tick();
    bus.lsu_resp_valid = 1'b0;
    check("ld_rf_wen", bus.rf_wen, 1'b1);
    tick();
    check("ld_pc", bus.pc, 64'h8000_000C);

    // beq taken
    use_br    = 1'b1;
    br_target = 64'h8000_0010;
    fetch_resp(32'h0000_0063);
    tick();
    tick();
    check("t3_no_rf_wen", bus.rf_wen, 1'b0);
    tick();
    use_br = 1'b0;
    check("t3_addr", bus.ifu_req_addr, 64'h8000_0010);
    check("t3_req", bus.ifu_req_valid, 1'b1);

    // Fetch response on the last allowed wait cycle is accepted
    tick();
    tick();
    tick();
    check("to_edge_wait", bus.ifu_req_valid, 1'b1);
    fetch_resp(32'h0010_0093);
    check("to_edge_halt", bus.halt, 1'b0);
    check("to_edge_inst", bus.inst_q, 32'h0010_0093);
    tick();
    tick();
    tick();
    check("to_edge_pc", bus.pc, 64'h8000_0014);

    // ebreak
    fetch_resp(32'h0010_0073);
    check("t4_decode_halt", bus.halt, 1'b0);
    tick();
    check("t4_halt", bus.halt, 1'b1);
    check("t4_err", bus.err, 2'd0);
    bus.ifu_resp_valid = 1'b1;
    bus.ifu_resp_inst  = 32'h0010_0093;
    tick();
    tick();
    bus.ifu_resp_valid = 1'b0;
    check("t4_no_req", bus.ifu_req_valid, 1'b0);
    check("t4_pc_frozen", bus.pc, 64'h8000_0014);
    check("t4_inst_frozen", bus.inst_q, 32'h0010_0073);
    check("t4_halt_sticky", bus.halt, 1'b1);

    // Illegal opcode
    rst = 1'b1;
    tick();
    check("rst2_halt", bus.halt, 1'b0);
    rst = 1'b0;
    tick();
    fetch_resp(32'h0000_007F);
    tick();
    check("t5_halt", bus.halt, 1'b1);
    check("t5_err", bus.err, 2'd1);
    check("t5_no_ex", bus.ex_en, 1'b0);

    // Fetch never answers
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("t5_to_wait4", bus.ifu_req_valid, 1'b1);
    check("t5_to_not_yet", bus.halt, 1'b0);
    tick();
    check("t5_to_halt", bus.halt, 1'b1);
    check("t5_to_err", bus.err, 2'd2);
    check("t5_to_req_drop", bus.ifu_req_valid, 1'b0);

    // Reset while a store is waiting in MEM
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fetch_resp(32'h0011_2023);
    tick();
    tick();
    tick();
    check("t6_in_mem", bus.lsu_req_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_pc", bus.pc, 64'h8000_0000);
    check("t6_lsu_req", bus.lsu_req_valid, 1'b0);
    check("t6_rf_wen", bus.rf_wen, 1'b0);
    check("t6_halt", bus.halt, 1'b0);
    rst = 1'b0;
    tick();
    check("t6_refetch", bus.ifu_req_valid, 1'b1);
    check("t6_addr", bus.ifu_req_addr, 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
